// File: rtl/ram64_loader.sv
// ram64_loader: stream-to-memory write engine feeding the RAM64 store.
// Accepts a block of 16-bit words over a valid/ready stream and writes them
// to consecutive RAM64 addresses from a latched base, wrapping modulo 64.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running 16-bit checksum
// of the accepted words of the current block on the `checksum` port.
module ram64_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  base,
  input  logic [6:0]  count,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] mem_in,
  output logic        mem_load,
  output logic [5:0]  mem_address,
  output logic        busy,
  output logic        done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [5:0]  addr;
  logic [6:0]  remaining;

  // The stream is open exactly while a block is running; busy also covers
  // the final write that is still on its way into RAM64.
  assign s_ready = (state == RUN);
  assign busy    = (state == RUN) | mem_load;

  // Block sequencer: latches the block on start, registers one RAM64 write
  // per accepted word and raises done together with the last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= 6'd0;
      remaining   <= 7'd0;
      mem_in      <= 16'd0;
      mem_load    <= 1'b0;
      mem_address <= 6'd0;
      done        <= 1'b0;
    end else begin
      mem_load <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base;
            remaining <= count;
            if (count == 7'd0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (s_valid) begin
            mem_in      <= s_data;
            mem_address <= addr;
            mem_load    <= 1'b1;
            addr        <= addr + 6'd1;
            remaining   <= remaining - 7'd1;
            if (remaining == 7'd1) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of accepted words, cleared when a new block is latched and
  // left untouched between blocks so it can be read after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= 16'd0;
    end else if (state == IDLE && start) begin
      checksum <= 16'd0;
    end else if (state == RUN && s_valid) begin
      checksum <= checksum + s_data;
    end
  end
`endif

endmodule

// File: tb/tb_ram64_loader.sv
// tb_ram64_loader: self-checking bench for ram64_loader with a RAM64 model,
// a cycle reference model with a write scoreboard, and block-level vectors.
module tb_ram64_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  base = 6'd0;
  logic [6:0]  count = 7'd0;
  logic [15:0] s_data = 16'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [5:0]  mem_address;
  logic        busy;
  logic        done;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int assertions = 0;
  int failures   = 0;

  ram64_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base        (base),
    .count       (count),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_address (mem_address),
    .busy        (busy),
    .done        (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  // RAM64 store downstream of the loader
  logic [15:0] ram [64];
  always @(posedge clk) begin
    if (mem_load) ram[mem_address] <= mem_in;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model and write scoreboard
  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         sb [$];
  wr_t         w;
  logic        m_run = 1'b0;
  logic [5:0]  m_addr = 6'd0;
  logic [6:0]  m_rem = 7'd0;
  logic        write_next = 1'b0;
  logic        done_next = 1'b0;
  logic [5:0]  held_addr = 6'd0;
  logic [15:0] held_data = 16'd0;
  logic [15:0] m_sum = 16'd0;

  // Check outputs produced by the last edge, then predict the next edge
  always @(negedge clk) begin
    if (write_next) begin
      w = sb.pop_front();
      held_addr = w.addr;
      held_data = w.data;
    end
    checkOutput("mem_load", 32'(mem_load), 32'(write_next));
    checkOutput("mem_in", 32'(mem_in), 32'(held_data));
    checkOutput("mem_address", 32'(mem_address), 32'(held_addr));
    checkOutput("done", 32'(done), 32'(done_next));
    checkOutput("s_ready", 32'(s_ready), 32'(m_run));
    checkOutput("busy", 32'(busy), 32'(m_run | write_next));
`ifdef LOADER_CHECKSUM_EN
    checkOutput("checksum", 32'(checksum), 32'(m_sum));
`endif
    write_next = 1'b0;
    done_next  = 1'b0;
    if (reset) begin
      sb.delete();
      m_run = 1'b0;
      m_addr = 6'd0;
      m_rem = 7'd0;
      held_addr = 6'd0;
      held_data = 16'd0;
      m_sum = 16'd0;
    end else if (!m_run) begin
      if (start) begin
        m_addr = base;
        m_rem  = count;
        m_sum  = 16'd0;
        if (count == 7'd0) done_next = 1'b1;
        else m_run = 1'b1;
      end
    end else if (s_valid) begin
      w.addr = m_addr;
      w.data = s_data;
      sb.push_back(w);
      write_next = 1'b1;
      m_addr = m_addr + 6'd1;
      m_sum = m_sum + s_data;
      if (m_rem == 7'd1) begin
        m_run = 1'b0;
        done_next = 1'b1;
      end
      m_rem = m_rem - 7'd1;
    end
  end

  typedef struct {
    logic [5:0]  base;
    logic [6:0]  count;
    logic [15:0] word0;
    logic [15:0] step;
    logic [15:0] pattern;
    logic [5:0]  exp_last_addr;
    logic [15:0] exp_sum;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] exp_ram [64];

  // Run one block: start pulse, then words on the cycles the pattern allows
  task automatic applyStimulus(input vec_t v);
    int i = 0;
    int k = 0;
    @(posedge clk); #1;
    start = 1'b1;
    base  = v.base;
    count = v.count;
    s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    base  = 6'($urandom);
    count = 7'($urandom_range(0, 64));
    while (i < int'(v.count)) begin
      s_valid = v.pattern[k % 16];
      if (s_valid) begin
        s_data = v.word0 + 16'(v.step * i);
        exp_ram[(int'(v.base) + i) % 64] = s_data;
        i++;
      end else begin
        s_data = 16'($urandom);
      end
      k++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{6'd0,  7'd64, 16'h0000, 16'h0001, 16'hFFFF, 6'd63, 16'h07E0};
    vecs[1] = '{6'd5,  7'd4,  16'h1111, 16'h1111, 16'hFFFF, 6'd8,  16'hAAAA};
    vecs[2] = '{6'd62, 7'd4,  16'h000A, 16'h0001, 16'hFFFF, 6'd1,  16'h002E};
    vecs[3] = '{6'd30, 7'd3,  16'h0300, 16'h0001, 16'h0029, 6'd32, 16'h0903};
    vecs[4] = '{6'd50, 7'd0,  16'h0000, 16'h0000, 16'hFFFF, 6'd32, 16'h0000};
    vecs[5] = '{6'd10, 7'd2,  16'hFFFF, 16'h0003, 16'hFFFF, 6'd11, 16'h0001};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset mem_load", 32'(mem_load), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);

    for (int n = 0; n < 6; n++) begin
      applyStimulus(vecs[n]);
      checkOutput($sformatf("vec%0d last address", n), 32'(mem_address),
                  32'(vecs[n].exp_last_addr));
      checkOutput($sformatf("vec%0d idle", n), 32'(busy), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      checkOutput($sformatf("vec%0d checksum", n), 32'(checksum), 32'(vecs[n].exp_sum));
`endif
    end

    // start while running with a different base is ignored
    @(posedge clk); #1;
    start = 1'b1; base = 6'd20; count = 7'd2;
    @(posedge clk); #1;
    base = 6'd40; count = 7'd5;
    s_valid = 1'b1; s_data = 16'h2020;
    exp_ram[20] = 16'h2020;
    @(posedge clk); #1;
    s_data = 16'h2021;
    exp_ram[21] = 16'h2021;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ignored start idle", 32'(s_ready), 32'd0);

    // reset after ten accepts of a 64-word block
    @(posedge clk); #1;
    start = 1'b1; base = 6'd0; count = 7'd64;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data = 16'h8000 + 16'(i);
      exp_ram[i] = s_data;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    s_data = 16'h800A;
    @(posedge clk); #1;
    checkOutput("mid reset mem_load", 32'(mem_load), 32'd0);
    checkOutput("mid reset mem_in", 32'(mem_in), 32'd0);
    checkOutput("mid reset mem_address", 32'(mem_address), 32'd0);
    checkOutput("mid reset s_ready", 32'(s_ready), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset done", 32'(done), 32'd0);
    reset = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // loader still usable after the interrupted block
    applyStimulus(vecs[1]);

    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    for (int a = 0; a < 64; a++) begin
      checkOutput($sformatf("ram[%0d]", a), 32'(ram[a]), 32'(exp_ram[a]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/ram64_loader.md
# ram64_loader

Stream-to-memory write engine that sits directly upstream of the 64-word RAM64 store and owns its `in`/`load`/`address` inputs. On a start command it accepts a block of 16-bit words over a valid/ready stream and writes them to consecutive RAM64 addresses, starting from a programmable base and wrapping modulo 64. It reports busy and done status and can optionally accumulate a checksum of the loaded block. It is used for memory initialisation and bulk data loading ahead of the CPU.

## Interface
Parameters: none (RAM64 geometry fixed: 6-bit address, 16-bit word).
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a block; sampled only in IDLE.
- `base` input 6: first RAM64 address, latched on accepted start.
- `count` input 7: number of words, 0..64, latched on accepted start.
- `s_data` input 16: stream word.
- `s_valid` input 1: `s_data` valid.
- `s_ready` output 1: loader can accept a word this cycle.
- `mem_in` output 16: to RAM64 `in`.
- `mem_load` output 1: to RAM64 `load`.
- `mem_address` output 6: to RAM64 `address`.
- `busy` output 1: block in progress or write still pending.
- `done` output 1: one-cycle completion pulse.
- `checksum` output 16: present only with `LOADER_CHECKSUM_EN`.

## Operation
- States: IDLE, RUN.
- IDLE: `s_ready`=0. On `start`=1: latch `addr`=`base`, `remaining`=`count`, clear checksum. If `count`≠0 go RUN; if `count`=0 stay IDLE and pulse `done` the next cycle, no write issued.
- RUN: `s_ready`=1 (combinational from state). Accept = `s_valid`&`s_ready`. On accept: register `mem_in`=`s_data`, `mem_address`=`addr`, `mem_load`=1; `addr`=`addr`+1 mod 64; `remaining`-=1. No accept: `mem_load`=0 next cycle, `mem_in`/`mem_address` hold.
- Last accept (`remaining`=1): next state IDLE, `done`=1 registered together with the final `mem_load`.
- `start` in RUN ignored; `base`/`count` changes after latch ignored.
- `busy` = (state==RUN) | `mem_load`.
- count=64: every address written exactly once, last address = `base`−1 mod 64.
- Words presented while in IDLE are not consumed (`s_ready`=0).

## Timing
- Reset values: state IDLE, `s_ready`=0, `mem_load`=0, `mem_in`=0, `mem_address`=0, `busy`=0, `done`=0, `checksum`=0.
- Start accepted at edge E0 → `s_ready`=1 in cycle after E0.
- Word accepted at edge En → `mem_load`/`mem_in`/`mem_address` valid in cycle after En; RAM64 captures at edge En+1. Write latency 2 edges from accept to stored.
- Throughput one word/cycle, back-to-back, no bubbles.
- `done` high for exactly one cycle, coincident with final `mem_load`; data readable from RAM64 after the following edge. A new `start` is accepted in that same `done` cycle (state already IDLE).
- `reset` mid-block: at the reset edge all outputs return to reset values; any pending `mem_load` is dropped (word not written); remaining count discarded.

## Configuration
- `LOADER_CHECKSUM_EN` defined: `checksum` port present; 16-bit sum mod 2^16 of all accepted words in the current block, cleared on accepted start, updated at each accept edge, stable from `done` until next start.
- Undefined: no `checksum` port, no adder or register.

## Test plan
- base=5, count=4, words 0x1111,0x2222,0x3333,0x4444 back-to-back → RAM64[5..8] hold them; `done` one pulse with 4th `mem_load`; `busy` drops the cycle after.
- base=62, count=4, words 0xA,0xB,0xC,0xD → addresses 62,63,0,1; RAM64[2] unchanged.
- count=3, `s_valid` toggled 1,0,0,1,0,1 → exactly 3 writes, `mem_load` low in gap cycles, `done` with 3rd write.
- count=0 start → `done` next cycle, `mem_load` never asserted, `s_ready` stays 0; `start` during RUN with different base → ignored.
- count=64, base=0, words 0..63 → RAM64[i]=i for all i; reset asserted after 10 accepts in a second block → outputs to reset values, RAM64[10..] retain first-block data.
- With `LOADER_CHECKSUM_EN`: words 0xFFFF,0x0002 → `checksum`=0x0001 at `done`; cleared to 0 at next start.
